// File: rtl/prbs_gen_chk.sv
// PRBS7/9/15/23/31 generator, DW bits per clock, plus a self-synchronising BER checker when PRBS_CHECKER_EN is defined.
// One cycle from en/din_vld to registered outputs; no backpressure, the stream advances only on en and din_vld.
module prbs_gen_chk #(
    parameter int DW       = 8,
    parameter int CNT_W    = 16,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [30:0]      seed,
    input  logic [2:0]       mode,
    input  logic             inj_err,
`ifdef PRBS_CHECKER_EN
    input  logic [DW-1:0]    din,
    input  logic             din_vld,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_word,
    output logic [CNT_W-1:0] err_cnt,
`endif
    output logic [DW-1:0]    dout,
    output logic             dout_vld
);

    // For every supported polynomial the long tap equals the order N.
    function automatic logic [4:0] tap_a(input logic [2:0] m);
        case (m)
            3'd1:    return 5'd9;
            3'd2:    return 5'd15;
            3'd3:    return 5'd23;
            3'd4:    return 5'd31;
            default: return 5'd7;
        endcase
    endfunction

    function automatic logic [4:0] tap_b(input logic [2:0] m);
        case (m)
            3'd1:    return 5'd5;
            3'd2:    return 5'd14;
            3'd3:    return 5'd18;
            3'd4:    return 5'd28;
            default: return 5'd6;
        endcase
    endfunction

    logic [2:0]    mode_r;
    logic [30:0]   s;
    logic [30:0]   gs;
    logic [DW-1:0] gw;
    logic          gb;
    logic [4:0]    pa;
    logic [4:0]    pb;
    logic [30:0]   seed_m;

    assign pa     = tap_a(mode_r);
    assign pb     = tap_b(mode_r);
    assign seed_m = seed & ((31'd1 << tap_a(mode)) - 31'd1);

    always_comb begin
        gs = s;
        gw = '0;
        gb = 1'b0;
        for (int i = 0; i < DW; i++) begin
            gb            = gs[pa - 5'd1] ^ gs[pb - 5'd1];
            gs            = {gs[29:0], gb};
            gw[DW-1-i]    = gb;
        end
    end

    // A zero seed would lock the LFSR up, so it is replaced by all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s        <= '1;
            mode_r   <= '0;
            dout     <= '0;
            dout_vld <= 1'b0;
        end else if (load) begin
            s        <= (seed_m == '0) ? '1 : seed_m;
            mode_r   <= mode;
            dout_vld <= 1'b0;
        end else if (en) begin
            s        <= gs;
            dout     <= gw ^ DW'(inj_err);
            dout_vld <= 1'b1;
        end else begin
            dout_vld <= 1'b0;
        end
    end

`ifdef PRBS_CHECKER_EN
    typedef enum logic {HUNT, LOCK} state_t;

    localparam int RMAX = (LOCK_CNT > LOSS_CNT) ? LOCK_CNT : LOSS_CNT;
    localparam int RW   = $clog2(RMAX + 1);
    localparam int SW   = CNT_W + 6;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t        st;
    logic [RW-1:0] run;
    logic [30:0]   h;
    logic [30:0]   ch;
    logic [DW-1:0] e;
    logic [5:0]    pc;
    logic [SW-1:0] sum;
    logic [CNT_W-1:0] cnt_sat;

    // The history holds received bits, so prediction resynchronises by itself after N clean bits.
    always_comb begin
        ch = h;
        e  = '0;
        pc = '0;
        for (int i = 0; i < DW; i++) begin
            e[DW-1-i] = din[DW-1-i] ^ ch[pa - 5'd1] ^ ch[pb - 5'd1];
            ch        = {ch[29:0], din[DW-1-i]};
            pc        = pc + 6'(e[DW-1-i]);
        end
    end

    assign sum     = SW'(err_cnt) + SW'(pc);
    assign cnt_sat = (sum > SW'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h        <= '1;
            st       <= HUNT;
            run      <= '0;
            locked   <= 1'b0;
            err_word <= 1'b0;
            err_cnt  <= '0;
        end else begin
            err_word <= din_vld & (|e);
            if (din_vld)
                h <= ch;
            if (clr_cnt)
                err_cnt <= '0;
            else if (din_vld && st == LOCK && !load)
                err_cnt <= cnt_sat;
            if (load) begin
                st     <= HUNT;
                locked <= 1'b0;
                run    <= '0;
            end else if (din_vld) begin
                case (st)
                    HUNT: begin
                        if (|e) begin
                            run <= '0;
                        end else if (run == RW'(LOCK_CNT - 1)) begin
                            st     <= LOCK;
                            locked <= 1'b1;
                            run    <= '0;
                        end else begin
                            run <= run + RW'(1);
                        end
                    end
                    LOCK: begin
                        if (!(|e)) begin
                            run <= '0;
                        end else if (run == RW'(LOSS_CNT - 1)) begin
                            st     <= HUNT;
                            locked <= 1'b0;
                            run    <= '0;
                        end else begin
                            run <= run + RW'(1);
                        end
                    end
                    default: begin
                        st     <= HUNT;
                        locked <= 1'b0;
                        run    <= '0;
                    end
                endcase
            end
        end
    end
`endif

endmodule

// File: tb/tb_prbs_gen_chk.sv
// Randomised bench for prbs_gen_chk; checker scenarios build only with PRBS_CHECKER_EN.
module tb_prbs_gen_chk;
    localparam int DW       = 8;
    localparam int CNT_W    = 4;
    localparam int LOCK_CNT = 4;
    localparam int LOSS_CNT = 4;
    localparam int CMAX     = (1 << CNT_W) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          load = 1'b0;
    logic          inj_err = 1'b0;
    logic [30:0]   seed = '0;
    logic [2:0]    mode = '0;
    logic [DW-1:0] dout;
    logic          dout_vld;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

`ifdef PRBS_CHECKER_EN
    logic [DW-1:0]    din;
    logic [DW-1:0]    xmask = '0;
    logic             din_vld;
    logic             clr_cnt = 1'b0;
    logic             locked;
    logic             err_word;
    logic [CNT_W-1:0] err_cnt;
    assign din     = dout ^ xmask;
    assign din_vld = dout_vld;
`endif

    prbs_gen_chk #(.DW(DW), .CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .seed(seed), .mode(mode), .inj_err(inj_err),
`ifdef PRBS_CHECKER_EN
        .din(din), .din_vld(din_vld), .clr_cnt(clr_cnt), .locked(locked), .err_word(err_word), .err_cnt(err_cnt),
`endif
        .dout(dout), .dout_vld(dout_vld)
    );

    // Reference model: sequences as bit histories (newest at the back), x[t] = x[t-a] ^ x[t-b].
    bit            gq[$];
    bit            rq[$];
    logic [2:0]    m_mode;
    logic [DW-1:0] m_dout;
    bit            m_vld;
    bit            m_locked;
    bit            m_err_word;
    int            m_err_cnt;
    int            m_run;

    function automatic void taps(input int md, output int a, output int b);
        case (md)
            1:       begin a = 9;  b = 5;  end
            2:       begin a = 15; b = 14; end
            3:       begin a = 23; b = 18; end
            4:       begin a = 31; b = 28; end
            default: begin a = 7;  b = 6;  end
        endcase
    endfunction

    task automatic model_reset();
        gq.delete();
        rq.delete();
        for (int i = 0; i < 31; i++) begin
            gq.push_back(1'b1);
            rq.push_back(1'b1);
        end
        m_mode = '0; m_dout = '0; m_vld = 0;
        m_locked = 0; m_err_word = 0; m_err_cnt = 0; m_run = 0;
    endtask

    task automatic model_gen(input bit g_en, input bit g_load, input logic [30:0] g_seed,
                             input logic [2:0] g_mode, input bit g_inj);
        int a, b;
        bit nb;
        bit sv[31];
        bit any;
        logic [DW-1:0] w;
        if (g_load) begin
            taps(int'(g_mode), a, b);
            any = 0;
            for (int i = 0; i < 31; i++) begin
                sv[i] = (i < a) ? g_seed[i] : 1'b0;
                any   = any | sv[i];
            end
            gq.delete();
            for (int i = 30; i >= 0; i--) gq.push_back(any ? sv[i] : 1'b1);
            m_mode = g_mode;
            m_vld  = 0;
        end else if (g_en) begin
            taps(int'(m_mode), a, b);
            w = '0;
            for (int k = 0; k < DW; k++) begin
                nb = gq[31-a] ^ gq[31-b];
                gq.push_back(nb);
                void'(gq.pop_front());
                w[DW-1-k] = nb;
            end
            if (g_inj) w[0] = ~w[0];
            m_dout = w;
            m_vld  = 1;
        end else begin
            m_vld = 0;
        end
    endtask

`ifdef PRBS_CHECKER_EN
    task automatic model_chk(input bit c_load, input bit c_clr);
        int a, b, nerr;
        bit rx, pred, was;
        logic [DW-1:0] w;
        taps(int'(m_mode), a, b);
        w = m_dout ^ xmask;
        nerr = 0;
        if (m_vld) begin
            for (int i = DW - 1; i >= 0; i--) begin
                rx   = w[i];
                pred = rq[31-a] ^ rq[31-b];
                if (rx != pred) nerr++;
                rq.push_back(rx);
                void'(rq.pop_front());
            end
        end
        was = m_locked;
        m_err_word = m_vld && (nerr > 0);
        if (c_clr) m_err_cnt = 0;
        else if (m_vld && was && !c_load) m_err_cnt = (m_err_cnt + nerr > CMAX) ? CMAX : m_err_cnt + nerr;
        if (c_load) begin
            m_locked = 0; m_run = 0;
        end else if (m_vld) begin
            if (!was) begin
                if (nerr == 0) begin
                    m_run++;
                    if (m_run == LOCK_CNT) begin m_locked = 1; m_run = 0; end
                end else m_run = 0;
            end else begin
                if (nerr > 0) begin
                    m_run++;
                    if (m_run == LOSS_CNT) begin m_locked = 0; m_run = 0; end
                end else m_run = 0;
            end
        end
    endtask
`endif

    task automatic step(input bit s_en, input bit s_load, input logic [30:0] s_seed,
                        input logic [2:0] s_mode, input bit s_inj, input bit s_clr);
        en = s_en; load = s_load; seed = s_seed; mode = s_mode; inj_err = s_inj;
`ifdef PRBS_CHECKER_EN
        clr_cnt = s_clr;
`endif
        @(posedge clk);
`ifdef PRBS_CHECKER_EN
        model_chk(s_load, s_clr);
`endif
        model_gen(s_en, s_load, s_seed, s_mode, s_inj);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #2;
        n_vec++;
        if (dout !== '0 || dout_vld !== 1'b0) begin
            n_err++; $display("FAIL reset_gen: dout=%h vld=%b, want 00/0", dout, dout_vld);
        end
`ifdef PRBS_CHECKER_EN
        n_vec++;
        if (locked !== 1'b0 || err_word !== 1'b0 || err_cnt !== '0) begin
            n_err++; $display("FAIL reset_chk: locked=%b err_word=%b err_cnt=%0d, want 0/0/0", locked, err_word, err_cnt);
        end
`endif
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (dout !== '0 || dout_vld !== 1'b0) begin
            n_err++; $display("FAIL async_reset: dout=%h vld=%b, want 00/0", dout, dout_vld);
        end
        model_reset();
        #2 rst_n = 1'b1;
    endtask

    task automatic test_prbs7();
        for (int i = 0; i < 130; i++) begin
            step(1, 0, 0, 0, 0, 0);
            n_vec++;
            if (dout !== m_dout || dout_vld !== 1'b1) begin
                n_err++; $display("FAIL prbs7_word%0d: dout=%h vld=%b, want %h/1", i, dout, dout_vld, m_dout);
            end
            if (i == 0 || i == 127) begin
                n_vec++;
                if (dout !== 8'h02) begin
                    n_err++; $display("FAIL prbs7_period_word%0d: dout=%h, want 02", i, dout);
                end
            end
`ifdef PRBS_CHECKER_EN
            n_vec++;
            if (locked !== m_locked || err_word !== m_err_word || err_cnt !== CNT_W'(m_err_cnt)) begin
                n_err++; $display("FAIL prbs7_chk%0d: %b/%b/%0d, want %b/%b/%0d", i, locked, err_word, err_cnt, m_locked, m_err_word, m_err_cnt);
            end
`endif
        end
    endtask

    task automatic test_load_zero();
        step(1, 1, 31'd0, 3'd2, 0, 0);
        n_vec++;
        if (dout_vld !== 1'b0 || dout !== m_dout) begin
            n_err++; $display("FAIL load_cycle: dout=%h vld=%b, want %h/0", dout, dout_vld, m_dout);
        end
        for (int i = 0; i < 32768; i++) begin
            step(1, 0, 0, 0, 0, 0);
            n_vec++;
            if (dout !== m_dout || dout_vld !== 1'b1) begin
                n_err++; $display("FAIL prbs15_word%0d: dout=%h vld=%b, want %h/1", i, dout, dout_vld, m_dout);
            end
            if (i == 0 || i == 32767) begin
                n_vec++;
                if (dout !== 8'h00) begin
                    n_err++; $display("FAIL prbs15_period_word%0d: dout=%h, want 00", i, dout);
                end
            end
`ifdef PRBS_CHECKER_EN
            n_vec++;
            if (locked !== m_locked || err_word !== m_err_word || err_cnt !== CNT_W'(m_err_cnt)) begin
                n_err++; $display("FAIL prbs15_chk%0d: %b/%b/%0d, want %b/%b/%0d", i, locked, err_word, err_cnt, m_locked, m_err_word, m_err_cnt);
            end
`endif
        end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            step(r < 75, r >= 96, 31'($urandom), 3'($urandom_range(0, 7)),
                 $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0);
            n_vec++;
            if (dout !== m_dout || dout_vld !== m_vld) begin
                n_err++; $display("FAIL random_gen%0d: dout=%h vld=%b, want %h/%b", i, dout, dout_vld, m_dout, m_vld);
            end
`ifdef PRBS_CHECKER_EN
            n_vec++;
            if (locked !== m_locked || err_word !== m_err_word || err_cnt !== CNT_W'(m_err_cnt)) begin
                n_err++; $display("FAIL random_chk%0d: %b/%b/%0d, want %b/%b/%0d", i, locked, err_word, err_cnt, m_locked, m_err_word, m_err_cnt);
            end
`endif
        end
    endtask

`ifdef PRBS_CHECKER_EN
    task automatic test_loopback_lock();
        int acc;
        bit seen;
        rst_n = 1'b0;
        model_reset();
        #2 rst_n = 1'b1;
        step(0, 1, 31'h7FFF_FFFF, 3'd4, 0, 0);
        acc = 0; seen = 0;
        for (int i = 0; i < 10000; i++) begin
            if (m_vld) acc++;
            step(1, 0, 0, 0, 0, 0);
            if (!seen && locked === 1'b1) begin
                seen = 1;
                n_vec++;
                if (acc !== LOCK_CNT) begin
                    n_err++; $display("FAIL lock_word: locked after word %0d, want %0d", acc, LOCK_CNT);
                end
            end
            n_vec++;
            if (dout !== m_dout || locked !== m_locked || err_word !== m_err_word || err_cnt !== CNT_W'(m_err_cnt)) begin
                n_err++; $display("FAIL loop31_%0d: %h/%b/%b/%0d, want %h/%b/%b/%0d", i, dout, locked, err_word, err_cnt, m_dout, m_locked, m_err_word, m_err_cnt);
            end
        end
        n_vec++;
        if (!seen || err_cnt !== '0 || locked !== 1'b1) begin
            n_err++; $display("FAIL loop31_end: seen=%b locked=%b err_cnt=%0d, want 1/1/0", seen, locked, err_cnt);
        end
    endtask

    task automatic test_inj_err();
        for (int i = 0; i < 12; i++) begin
            step(1, 0, 0, 0, i == 0, 0);
            n_vec++;
            if (err_word !== m_err_word || locked !== 1'b1) begin
                n_err++; $display("FAIL inj_step%0d: err_word=%b locked=%b, want %b/1", i, err_word, locked, m_err_word);
            end
        end
        n_vec++;
        if (err_cnt !== CNT_W'(3)) begin
            n_err++; $display("FAIL inj_count: err_cnt=%0d, want 3", err_cnt);
        end
    endtask

    task automatic test_garbage();
        int held;
        bit relocked;
        for (int i = 0; i < 4; i++) begin
            xmask = DW'($urandom) | 8'h80;
            step(1, 0, 0, 0, 0, 0);
            n_vec++;
            if (locked !== m_locked || err_cnt !== CNT_W'(m_err_cnt)) begin
                n_err++; $display("FAIL garbage%0d: locked=%b err_cnt=%0d, want %b/%0d", i, locked, err_cnt, m_locked, m_err_cnt);
            end
        end
        n_vec++;
        if (locked !== 1'b0) begin
            n_err++; $display("FAIL garbage_loss: locked=%b, want 0", locked);
        end
        xmask = '0;
        held = m_err_cnt;
        relocked = 0;
        for (int i = 0; i < 60 && !relocked; i++) begin
            step(1, 0, 0, 0, 0, 0);
            n_vec++;
            if (locked !== m_locked || err_word !== m_err_word) begin
                n_err++; $display("FAIL relock%0d: locked=%b err_word=%b, want %b/%b", i, locked, err_word, m_locked, m_err_word);
            end
            n_vec++;
            if (err_cnt !== CNT_W'(held)) begin
                n_err++; $display("FAIL hunt_cnt%0d: err_cnt=%0d, want %0d", i, err_cnt, held);
            end
            if (m_locked) relocked = 1;
        end
        n_vec++;
        if (!relocked || locked !== 1'b1) begin
            n_err++; $display("FAIL relock_timeout: locked=%b, want 1", locked);
        end
    endtask

    task automatic test_saturate();
        step(1, 0, 0, 0, 0, 1);
        n_vec++;
        if (err_cnt !== '0 || locked !== 1'b1) begin
            n_err++; $display("FAIL sat_clr: err_cnt=%0d locked=%b, want 0/1", err_cnt, locked);
        end
        xmask = '1;
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        n_vec++;
        if (err_cnt !== CNT_W'(CMAX) || locked !== 1'b1) begin
            n_err++; $display("FAIL sat_max: err_cnt=%0d locked=%b, want %0d/1", err_cnt, locked, CMAX);
        end
        step(1, 0, 0, 0, 0, 1);
        n_vec++;
        if (err_cnt !== '0 || locked !== 1'b1) begin
            n_err++; $display("FAIL sat_clr_wins: err_cnt=%0d locked=%b, want 0/1", err_cnt, locked);
        end
        xmask = '0;
        for (int i = 0; i < 40; i++) begin
            step(1, 0, 0, 0, 0, 0);
            n_vec++;
            if (locked !== m_locked || err_word !== m_err_word || err_cnt !== CNT_W'(m_err_cnt)) begin
                n_err++; $display("FAIL sat_after%0d: %b/%b/%0d, want %b/%b/%0d", i, locked, err_word, err_cnt, m_locked, m_err_word, m_err_cnt);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_prbs7();
        test_load_zero();
        test_random();
`ifdef PRBS_CHECKER_EN
        test_loopback_lock();
        test_inj_err();
        test_garbage();
        test_saturate();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
